// File: rtl/pooling_output_interface.sv
// Pooling output deserializer: packs OUTPUT_SIZE pooled words into one wide
// word, first word received in the most-significant slot. A row-end marker
// flushes a partial word with the unwritten slots zero-padded.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready is combinational)
//   in_data, in_last     pooled word and row-end marker
//   out_valid/out_ready  output handshake
//   out_data             packed word, slot k at [(OUTPUT_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH]
//   out_count            number of valid slots (1..OUTPUT_SIZE)
//   out_row_idx          index of this packed word within its row
//   out_last             packed word ends a row
module pooling_output_interface #(
    parameter int unsigned OUTPUT_SIZE = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ROW_WIDTH   = 3,
    parameter int unsigned CNT_WIDTH   = $clog2(OUTPUT_SIZE + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]              out_count,
    output logic [ROW_WIDTH-1:0]              out_row_idx,
    output logic                              out_last
);

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } state_t;

    typedef logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0] pack_t;

    state_t                 state, state_n;
    logic [CNT_WIDTH-1:0]   fill_cnt, fill_n;
    pack_t                  acc, acc_n, acc_sum;
    logic [ROW_WIDTH-1:0]   row_cnt, row_n;
    pack_t                  data_q, data_n;
    logic                   valid_n;
    logic [CNT_WIDTH-1:0]   count_n;
    logic [ROW_WIDTH-1:0]   row_idx_n;
    logic                   last_n;
    logic                   accept;
    logic                   complete;

    // Hold off upstream only while an untaken output is pending.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((fill_cnt == CNT_WIDTH'(OUTPUT_SIZE - 1)) || in_last);
    assign out_data = data_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            fill_cnt    <= '0;
            acc         <= '0;
            row_cnt     <= '0;
            out_valid   <= 1'b0;
            data_q      <= '0;
            out_count   <= '0;
            out_row_idx <= '0;
            out_last    <= 1'b0;
        end else begin
            state       <= state_n;
            fill_cnt    <= fill_n;
            acc         <= acc_n;
            row_cnt     <= row_n;
            out_valid   <= valid_n;
            data_q      <= data_n;
            out_count   <= count_n;
            out_row_idx <= row_idx_n;
            out_last    <= last_n;
        end
    end

    // Next-state: fill slots, and on completion move the packed word to the output.
    always_comb begin
        state_n   = state;
        fill_n    = fill_cnt;
        acc_n     = acc;
        row_n     = row_cnt;
        valid_n   = out_valid && !out_ready;
        data_n    = data_q;
        count_n   = out_count;
        row_idx_n = out_row_idx;
        last_n    = out_last;

        // Accumulation including the current word; slot k lives at packed index OUTPUT_SIZE-1-k.
        acc_sum = acc;
        for (int unsigned k = 0; k < OUTPUT_SIZE; k++) begin
            if (fill_cnt == CNT_WIDTH'(k)) begin
                acc_sum[OUTPUT_SIZE-1-k] = in_data;
            end
        end

        case (state)
            EMPTY: begin
                if (accept && !complete) begin
                    state_n = FILLING;
                end
            end
            FILLING: begin
                if (complete) begin
                    state_n = EMPTY;
                end
            end
            default: state_n = EMPTY;
        endcase

        if (complete) begin
            valid_n   = 1'b1;
            data_n    = acc_sum;
            count_n   = fill_cnt + CNT_WIDTH'(1);
            row_idx_n = row_cnt;
            last_n    = in_last;
            acc_n     = '0;
            fill_n    = '0;
            row_n     = in_last ? '0 : row_cnt + ROW_WIDTH'(1);
        end else if (accept) begin
            acc_n  = acc_sum;
            fill_n = fill_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pooling_output_interface.sv
// Self-checking bench for pooling_output_interface with a queue-based reference model.
module tb_pooling_output_interface;

    localparam int unsigned OS = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 3;
    localparam int unsigned CW = 2;

    typedef struct {
        logic [OS*DW-1:0] data;
        logic [CW-1:0]    count;
        logic             last;
        logic [RW-1:0]    row;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OS*DW-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic [RW-1:0]    out_row_idx;
    logic             out_last;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit rand_rdy     = 0;

    logic [DW-1:0] grp[$];
    int            row_m = 0;
    rec_t          exp_q[$];
    rec_t          got_q[$];
    int            xfer_cyc[$];

    pooling_output_interface #(
        .OUTPUT_SIZE(OS), .DATA_WIDTH(DW), .ROW_WIDTH(RW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_row_idx(out_row_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom % 4) != 0;
        end
    end

    // Reference model: group words per row, emit a record when full or at row end.
    task automatic model_accept(input logic [DW-1:0] w, input logic last);
        rec_t r;
        grp.push_back(w);
        if (grp.size() == OS || last) begin
            r.data = '0;
            for (int k = 0; k < grp.size(); k++) r.data[(OS-k)*DW-1 -: DW] = grp[k];
            r.count = CW'(grp.size());
            r.last  = last;
            r.row   = RW'(row_m);
            row_m   = last ? 0 : (row_m + 1) % (1 << RW);
            grp.delete();
            exp_q.push_back(r);
        end
    endtask

    // Scoreboard: every output transfer is compared against the model.
    always @(negedge clk) begin
        rec_t g;
        rec_t e;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            g.data = out_data; g.count = out_count; g.last = out_last; g.row = out_row_idx;
            got_q.push_back(g);
            xfer_cyc.push_back(cyc);
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_unexpected: got data=%h count=%0d, required no output", g.data, g.count);
            end else begin
                e = exp_q.pop_front();
                if (g.data !== e.data || g.count !== e.count || g.last !== e.last || g.row !== e.row) begin
                    tests_failed++;
                    $display("FAIL scoreboard_word: got data=%h cnt=%0d last=%b row=%0d, required data=%h cnt=%0d last=%b row=%0d",
                             g.data, g.count, g.last, g.row, e.data, e.count, e.last, e.row);
                end
            end
        end
    end

    // Drive one word and hold it until accepted; returns at posedge+1 after the accept edge.
    task automatic send(input logic [DW-1:0] w, input logic last);
        bit done;
        done = 0;
        in_valid = 1'b1; in_data = w; in_last = last;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model_accept(w, last);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL send_timeout: word %h not accepted, required accept within 200 cycles", w);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        idle();
        while ((exp_q.size() != 0 || out_valid === 1'b1) && c < 300) begin
            @(posedge clk); #1; c++;
        end
        tests_run++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain: pending=%0d out_valid=%b, required 0 and 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0 || out_row_idx !== '0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d r=%0d l=%b, required all 0",
                     out_valid, out_data, out_count, out_row_idx, out_last);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        idle();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 96'h3F800000_40000000_40400000 || out_count !== 2'd3 ||
            out_last !== 1'b1 || out_row_idx !== 3'd0) begin
            tests_failed++;
            $display("FAIL basic_word: got v=%b d=%h c=%0d l=%b r=%0d, required 1 3f800000_40000000_40400000 3 1 0",
                     out_valid, out_data, out_count, out_last, out_row_idx);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_partial_row();
        logic [DW-1:0] w6;
        logic [OS*DW-1:0] exp_d;
        got_q.delete();
        out_ready = 1'b1;
        w6 = '0;
        for (int i = 0; i < 7; i++) begin
            w6 = $urandom;
            send(w6, i == 6);
        end
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b1);
        drain();
        exp_d = {w6, 64'h0};
        tests_run++;
        if (got_q.size() != 4) begin
            tests_failed++;
            $display("FAIL partial_count: got %0d outputs, required 4", got_q.size());
        end else begin
            if (got_q[0].row !== 3'd0 || got_q[1].row !== 3'd1 || got_q[2].row !== 3'd2 || got_q[3].row !== 3'd0 ||
                got_q[0].count !== 2'd3 || got_q[1].count !== 2'd3 || got_q[2].count !== 2'd1 ||
                got_q[2].data !== exp_d || got_q[2].last !== 1'b1 || got_q[3].count !== 2'd2) begin
                tests_failed++;
                $display("FAIL partial_fields: got rows %0d,%0d,%0d,%0d cnts %0d,%0d,%0d data2=%h, required rows 0,1,2,0 cnts 3,3,1 data2=%h",
                         got_q[0].row, got_q[1].row, got_q[2].row, got_q[3].row,
                         got_q[0].count, got_q[1].count, got_q[2].count, got_q[2].data, exp_d);
            end
        end
    endtask

    task automatic test_stall();
        logic [OS*DW-1:0] snap_d;
        logic [CW-1:0]    snap_c;
        logic [RW-1:0]    snap_r;
        logic             snap_l;
        got_q.delete();
        out_ready = 1'b0;
        send(32'hA0000001, 1'b0);
        send(32'hA0000002, 1'b0);
        send(32'hA0000003, 1'b1);
        in_valid = 1'b1; in_data = 32'hB0000001; in_last = 1'b0;
        @(negedge clk);
        snap_d = out_data; snap_c = out_count; snap_r = out_row_idx; snap_l = out_last;
        tests_run++;
        if (out_valid !== 1'b1 || snap_d !== 96'hA0000001_A0000002_A0000003) begin
            tests_failed++;
            $display("FAIL stall_pending: got v=%b d=%h, required 1 a0000001_a0000002_a0000003", out_valid, snap_d);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== snap_d || out_count !== snap_c ||
                out_row_idx !== snap_r || out_last !== snap_l) begin
                tests_failed++;
                $display("FAIL stall_hold: cycle %0d got in_ready=%b v=%b d=%h, required 0 1 %h", i, in_ready, out_valid, out_data, snap_d);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'hB0000001, 1'b0);
        send(32'hB0000002, 1'b0);
        send(32'hB0000003, 1'b1);
        drain();
        tests_run++;
        if (got_q.size() != 2) begin
            tests_failed++;
            $display("FAIL stall_resume: got %0d outputs, required 2", got_q.size());
        end else if (got_q[1].data !== 96'hB0000001_B0000002_B0000003) begin
            tests_failed++;
            $display("FAIL stall_resume: got %h, required b0000001_b0000002_b0000003", got_q[1].data);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        xfer_cyc.delete();
        out_ready = 1'b1;
        start = cyc;
        for (int i = 0; i < 9; i++) send($urandom, i == 8);
        tests_run++;
        if (cyc - start != 9) begin
            tests_failed++;
            $display("FAIL b2b_input: got %0d cycles for 9 words, required 9", cyc - start);
        end
        drain();
        tests_run++;
        if (xfer_cyc.size() != 3) begin
            tests_failed++;
            $display("FAIL b2b_pulses: got %0d outputs, required 3", xfer_cyc.size());
        end else if (xfer_cyc[1] - xfer_cyc[0] != 3 || xfer_cyc[2] - xfer_cyc[1] != 3) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got gaps %0d,%0d, required 3,3", xfer_cyc[1] - xfer_cyc[0], xfer_cyc[2] - xfer_cyc[1]);
        end
    endtask

    task automatic test_async_reset();
        got_q.delete();
        out_ready = 1'b1;
        send(32'hDEAD0001, 1'b0);
        send(32'hDEAD0002, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        grp.delete();
        row_m = 0;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0 || out_row_idx !== '0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%b d=%h c=%0d, required all 0", out_valid, out_data, out_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(32'h00000C01, 1'b0);
        send(32'h00000C02, 1'b0);
        send(32'h00000C03, 1'b0);
        drain();
        tests_run++;
        if (got_q.size() != 1 || got_q[0].data !== 96'h00000C01_00000C02_00000C03) begin
            tests_failed++;
            $display("FAIL reset_discard: got %0d outputs, required 1 holding 00000c01_00000c02_00000c03", got_q.size());
        end
        // Close the row so later tests start at row index 0.
        send(32'h0, 1'b1);
        drain();
    endtask

    task automatic test_short_rows();
        bit bad;
        got_q.delete();
        out_ready = 1'b1;
        for (int r = 0; r < 9; r++) begin
            send($urandom, 1'b0);
            send($urandom, 1'b1);
        end
        drain();
        bad = (got_q.size() != 9);
        foreach (got_q[i]) if (got_q[i].count !== 2'd2 || got_q[i].last !== 1'b1 || got_q[i].row !== 3'd0) bad = 1;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL short_rows: got %0d outputs (first cnt=%0d row=%0d), required 9 with cnt 2 last 1 row 0",
                     got_q.size(), got_q.size() > 0 ? got_q[0].count : 0, got_q.size() > 0 ? got_q[0].row : 0);
        end
    endtask

    task automatic test_row_wrap();
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 27; i++) send($urandom, i == 26);
        drain();
        tests_run++;
        if (got_q.size() != 9) begin
            tests_failed++;
            $display("FAIL row_wrap: got %0d outputs, required 9", got_q.size());
        end else if (got_q[7].row !== 3'd7 || got_q[8].row !== 3'd0 || got_q[8].last !== 1'b1) begin
            tests_failed++;
            $display("FAIL row_wrap: got rows %0d,%0d, required 7,0", got_q[7].row, got_q[8].row);
        end
    endtask

    task automatic test_random();
        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom % 4 == 0) begin
                // Idle cycle with a stray in_last that must be ignored.
                in_valid = 1'b0; in_last = 1'b1; in_data = $urandom;
                @(posedge clk); #1;
            end
            send($urandom, ($urandom % 6) == 0);
        end
        send($urandom, 1'b1);
        idle();
        rand_rdy = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial_row();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_short_rows();
        test_row_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
